// File: rtl/pkt_bufid_manage.sv
`default_nettype none
// ============================================================================
// Module   : pkt_bufid_manage
// Purpose  : Free-list manager for packet buffer IDs. After reset it loads a
//            circular RAM pool with IDs 0..BUFID_NUM-1, then keeps one
//            prefetched ID presented (level valid) until it is acknowledged.
//            Released IDs are appended to the pool in FIFO order.
// Ports    : clk_sys / reset          - clock, synchronous active-high reset
//            o_pkt_bufid_wr           - presented ID valid (level)
//            ov_pkt_bufid             - presented ID
//            i_pkt_bufid_ack          - presented ID consumed (pulse)
//            i_pkt_bufid_free         - release strobe (pulse)
//            iv_pkt_bufid_free        - ID being released
//            ov_free_bufid_num        - IDs held in the pool RAM
//            o_init_done              - pool initialisation complete
//            o_free_err               - release dropped (pulse)
//            ov_bufid_manage_state    - FSM state for debug
// Revision : 1.0 - initial release
// ============================================================================
module pkt_bufid_manage #(
    parameter int BUFID_WIDTH = 9,
    parameter int BUFID_NUM   = 512
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    output logic                   o_pkt_bufid_wr,
    output logic [BUFID_WIDTH-1:0] ov_pkt_bufid,
    input  logic                   i_pkt_bufid_ack,
    input  logic                   i_pkt_bufid_free,
    input  logic [BUFID_WIDTH-1:0] iv_pkt_bufid_free,
    output logic [BUFID_WIDTH:0]   ov_free_bufid_num,
    output logic                   o_init_done,
    output logic                   o_free_err,
    output logic [1:0]             ov_bufid_manage_state
);

    localparam int                   c_aw        = (BUFID_NUM > 1) ? $clog2(BUFID_NUM) : 1;
    localparam logic [BUFID_WIDTH-1:0] c_last_id   = BUFID_WIDTH'(BUFID_NUM - 1);
    localparam logic [BUFID_WIDTH:0]   c_pool_full = (BUFID_WIDTH + 1)'(BUFID_NUM);

    typedef enum logic [1:0] {
        INIT_S    = 2'b00,
        FETCH_S   = 2'b01,
        WAIT_S    = 2'b11,
        PRESENT_S = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [BUFID_WIDTH-1:0] r_ram [BUFID_NUM];
    logic [BUFID_WIDTH-1:0] r_rd_data;
    logic [BUFID_WIDTH-1:0] r_init_cnt;
    logic [BUFID_WIDTH-1:0] r_rd_ptr;
    logic [BUFID_WIDTH-1:0] r_wr_ptr;
    logic [BUFID_WIDTH:0]   r_count;
    logic                   r_init_done;
    logic                   r_free_err;
    logic                   r_bufid_wr;
    logic [BUFID_WIDTH-1:0] r_bufid;

    logic                   w_pop;
    logic                   w_free_ok;
    logic                   w_free_err;
    logic                   w_ram_we;
    logic [BUFID_WIDTH-1:0] w_ram_waddr;
    logic [BUFID_WIDTH-1:0] w_ram_wdata;

    function automatic logic [BUFID_WIDTH-1:0] next_ptr(input logic [BUFID_WIDTH-1:0] p);
        return (p == c_last_id) ? '0 : p + 1'b1;
    endfunction

    // Pop and release both look at the pre-update count. A release into an
    // empty pool therefore cannot be popped in the same cycle, so the read
    // address never equals the address being written.
    assign w_pop      = (r_state == FETCH_S) && (r_count != '0);
    assign w_free_ok  = i_pkt_bufid_free && (r_state != INIT_S)
                        && ({1'b0, iv_pkt_bufid_free} < c_pool_full)
                        && (r_count < c_pool_full);
    assign w_free_err = i_pkt_bufid_free && !w_free_ok;

    // Initialisation and release share the single RAM write port; releases
    // are never accepted during INIT_S so the two cannot collide.
    assign w_ram_we    = (r_state == INIT_S) || w_free_ok;
    assign w_ram_waddr = (r_state == INIT_S) ? r_init_cnt : r_wr_ptr;
    assign w_ram_wdata = (r_state == INIT_S) ? r_init_cnt : iv_pkt_bufid_free;

    always_ff @(posedge clk_sys) begin
        if (w_ram_we) begin
            r_ram[w_ram_waddr[c_aw-1:0]] <= w_ram_wdata;
        end
        if (w_pop) begin
            r_rd_data <= r_ram[r_rd_ptr[c_aw-1:0]];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= INIT_S;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            INIT_S:    if (r_init_cnt == c_last_id) w_state_nxt = FETCH_S;
            FETCH_S:   if (w_pop) w_state_nxt = WAIT_S;
            WAIT_S:    w_state_nxt = PRESENT_S;
            PRESENT_S: if (i_pkt_bufid_ack) w_state_nxt = FETCH_S;
            default:   w_state_nxt = INIT_S;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_init_cnt  <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_init_done <= 1'b0;
            r_free_err  <= 1'b0;
            r_bufid_wr  <= 1'b0;
            r_bufid     <= '0;
        end else begin
            r_free_err <= w_free_err;

            if (r_state == INIT_S) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (r_init_cnt == c_last_id) begin
                    r_init_cnt  <= '0;
                    r_count     <= c_pool_full;
                    r_wr_ptr    <= '0;
                    r_init_done <= 1'b1;
                end
            end else begin
                if (w_free_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
                if (w_pop)     r_rd_ptr <= next_ptr(r_rd_ptr);
                // Simultaneous release and pop leaves the count unchanged.
                if (w_free_ok && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_free_ok && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end

            if (r_state == WAIT_S) begin
                r_bufid_wr <= 1'b1;
                r_bufid    <= r_rd_data;
            end else if ((r_state == PRESENT_S) && i_pkt_bufid_ack) begin
                r_bufid_wr <= 1'b0;
                r_bufid    <= '0;
            end
        end
    end

    assign o_pkt_bufid_wr        = r_bufid_wr;
    assign ov_pkt_bufid          = r_bufid;
    assign ov_free_bufid_num     = r_count;
    assign o_init_done           = r_init_done;
    assign o_free_err            = r_free_err;
    assign ov_bufid_manage_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pkt_bufid_manage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_bufid_manage
// Purpose  : Self-checking bench for pkt_bufid_manage. Two instances are used
//            (BUFID_NUM = 512 and 4); the idle one is held in reset. Every
//            cycle the selected instance is compared to a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_bufid_manage;

    localparam int W = 9;
    localparam int ST_INIT = 0, ST_FETCH = 1, ST_WAIT = 3, ST_PRES = 2;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic         reset_req = 1'b1;
    logic         sel = 1'b0;
    logic         ack = 1'b0;
    logic         fr = 1'b0;
    logic [W-1:0] fid = '0;

    logic         rst_b, rst_s;
    logic         wr_b, wr_s, done_b, done_s, err_b, err_s;
    logic [W-1:0] id_b, id_s;
    logic [W:0]   num_b, num_s;
    logic [1:0]   st_b, st_s;

    assign rst_b = reset_req | sel;
    assign rst_s = reset_req | ~sel;

    pkt_bufid_manage #(.BUFID_WIDTH(W), .BUFID_NUM(512)) u_dut_big (
        .clk_sys(clk_sys), .reset(rst_b),
        .o_pkt_bufid_wr(wr_b), .ov_pkt_bufid(id_b),
        .i_pkt_bufid_ack(ack), .i_pkt_bufid_free(fr), .iv_pkt_bufid_free(fid),
        .ov_free_bufid_num(num_b), .o_init_done(done_b), .o_free_err(err_b),
        .ov_bufid_manage_state(st_b)
    );

    pkt_bufid_manage #(.BUFID_WIDTH(W), .BUFID_NUM(4)) u_dut_small (
        .clk_sys(clk_sys), .reset(rst_s),
        .o_pkt_bufid_wr(wr_s), .ov_pkt_bufid(id_s),
        .i_pkt_bufid_ack(ack), .i_pkt_bufid_free(fr), .iv_pkt_bufid_free(fid),
        .ov_free_bufid_num(num_s), .o_init_done(done_s), .o_free_err(err_s),
        .ov_bufid_manage_state(st_s)
    );

    wire         o_wr   = sel ? wr_s   : wr_b;
    wire [W-1:0] o_id   = sel ? id_s   : id_b;
    wire [W:0]   o_num  = sel ? num_s  : num_b;
    wire         o_done = sel ? done_s : done_b;
    wire         o_err  = sel ? err_s  : err_b;
    wire [1:0]   o_st   = sel ? st_s   : st_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d observed %0d required %0d", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_n = 512;
    int m_stage = ST_INIT;
    int m_init = 0;
    bit m_done = 0;
    bit m_err = 0;
    bit m_vld = 0;
    int m_vid = 0;
    int m_fetched = 0;
    int m_pool[$];
    int held[$];

    task automatic model_step(input bit a, input bit f, input int id);
        int pre;
        if (reset_req) begin
            m_stage = ST_INIT; m_init = 0; m_done = 0; m_err = 0;
            m_vld = 0; m_vid = 0; m_pool.delete();
            return;
        end
        pre   = m_pool.size();
        m_err = f && (m_stage == ST_INIT || id >= m_n || pre == m_n);
        if (m_stage == ST_INIT) begin
            m_init++;
            if (m_init == m_n) begin
                for (int i = 0; i < m_n; i++) m_pool.push_back(i);
                m_done  = 1;
                m_stage = ST_FETCH;
            end
        end else begin
            case (m_stage)
                ST_FETCH: if (pre > 0) begin m_fetched = m_pool.pop_front(); m_stage = ST_WAIT; end
                ST_WAIT:  begin m_vld = 1; m_vid = m_fetched; m_stage = ST_PRES; end
                ST_PRES:  if (a) begin m_vld = 0; m_vid = 0; m_stage = ST_FETCH; end
                default:  ;
            endcase
            if (f && !m_err) m_pool.push_back(id);
        end
    endtask

    task automatic tick(input bit a, input bit f, input int id);
        ack = a; fr = f; fid = W'(id);
        @(posedge clk_sys);
        model_step(a, f, id);
        #1;
        ack = 1'b0; fr = 1'b0;
        cyc++;
        check_value("wr",    32'(o_wr),   32'(m_vld));
        check_value("id",    32'(o_id),   32'(m_vid));
        check_value("num",   32'(o_num),  32'(m_pool.size()));
        check_value("done",  32'(o_done), 32'(m_done));
        check_value("err",   32'(o_err),  32'(m_err));
        check_value("state", 32'(o_st),   32'(m_stage));
    endtask

    task automatic do_reset();
        reset_req = 1'b1;
        held.delete();
        tick(0, 0, 0);
        check_value("rst_outputs", {o_wr, o_id, o_num, o_done, o_err, o_st}, 0);
        reset_req = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_wr();
        int k = 0;
        while (!o_wr && k < 2000) begin tick(0, 0, 0); k++; end
        check_value("wait_wr", 32'(o_wr), 1);
    endtask

    task automatic init_seq();
        int done_cyc = -1;
        int wr_cyc = -1;
        if (o_done) done_cyc = cyc;
        for (int k = 0; k < m_n + 20 && wr_cyc < 0; k++) begin
            tick(0, 0, 0);
            if (o_done && done_cyc < 0) done_cyc = cyc;
            if (o_wr) wr_cyc = cyc;
        end
        check_value("done_cyc", done_cyc, m_n);
        check_value("wr_cyc",   wr_cyc,   m_n + 2);
        check_value("first_id", 32'(o_id),  0);
        check_value("init_num", 32'(o_num), m_n - 1);
    endtask

    task automatic rand_phase(input int n_cyc, input int idmax);
        for (int i = 0; i < n_cyc; i++) begin
            bit a;
            bit f;
            int id;
            a  = ($urandom_range(0, 2) == 0);
            f  = ($urandom_range(0, 3) == 0);
            id = $urandom_range(0, idmax);
            if (f && held.size() > 0 && $urandom_range(0, 4) != 0) begin
                int k = $urandom_range(0, held.size() - 1);
                id = held[k];
                held.delete(k);
            end
            if (a && m_vld) held.push_back(m_vid);
            tick(a, f, id);
        end
    endtask

    initial begin
        int k;
        // ===== BUFID_NUM = 512 =====
        sel = 1'b0; m_n = 512;
        do_reset();
        init_seq();

        // Three acks: IDs 0,1,2 then 3; each valid 3 cycles after its ack.
        for (int i = 0; i < 3; i++) begin
            check_value("consume_id", 32'(o_id), i);
            tick(1, 0, 0);
            k = 1;
            while (!o_wr && k < 20) begin tick(0, 0, 0); k++; end
            check_value("ack_lat", k, 3);
        end
        check_value("consume_num", 32'(o_num), 508);

        // Release ID 0 in the same cycle FETCH_S pops.
        tick(1, 0, 0);
        check_value("pre_pop_num", 32'(o_num), 508);
        tick(0, 1, 0);
        check_value("simul_num", 32'(o_num), 508);
        for (int e = 4; e <= 512; e++) begin
            wait_wr();
            check_value("order", 32'(o_id), (e == 512) ? 0 : e);
            tick(1, 0, 0);
        end
        tick(0, 0, 0); tick(0, 0, 0);
        check_value("drained_num", 32'(o_num), 0);

        // Present ID 7, then reset mid-operation.
        tick(0, 1, 7);
        tick(0, 0, 0); tick(0, 0, 0);
        check_value("refill_wr", 32'(o_wr), 1);
        check_value("refill_id", 32'(o_id), 7);
        do_reset();
        init_seq();
        rand_phase(3000, 511);

        // ===== BUFID_NUM = 4 =====
        sel = 1'b1; m_n = 4;
        do_reset();
        tick(0, 1, 1);
        check_value("err_in_init", 32'(o_err), 1);
        init_seq();

        // Exhaust and refill.
        for (int i = 0; i < 4; i++) begin
            wait_wr();
            check_value("exhaust_id", 32'(o_id), i);
            tick(1, 0, 0);
        end
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        check_value("empty_wr",    32'(o_wr),  0);
        check_value("empty_num",   32'(o_num), 0);
        check_value("empty_state", 32'(o_st),  1);
        tick(0, 1, 2);
        tick(0, 0, 0); tick(0, 0, 0);
        check_value("empty_refill_wr", 32'(o_wr), 1);
        check_value("empty_refill_id", 32'(o_id), 2);

        // Error cases after init.
        do_reset();
        init_seq();
        tick(0, 1, 0);
        check_value("free_ok_num", 32'(o_num), 4);
        check_value("free_ok_err", 32'(o_err), 0);
        tick(0, 1, 0);
        check_value("dbl_free_err", 32'(o_err), 1);
        check_value("dbl_free_num", 32'(o_num), 4);
        tick(0, 0, 0);
        check_value("err_pulse_end", 32'(o_err), 0);
        tick(0, 1, 5);
        check_value("bad_id_err", 32'(o_err), 1);
        rand_phase(2000, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_bufid_manage.md
# pkt_bufid_manage

Free-list manager for packet buffer IDs in the network input process, directly upstream of the frame parser's descriptor send stage. After reset it fills a pool with IDs 0..BUFID_NUM-1, then keeps one prefetched ID presented as a level-valid write (`o_pkt_bufid_wr` / `ov_pkt_bufid`) until the descriptor send stage acknowledges it. The transmit side releases IDs back into the pool once frames have been read out of the buffer.

## Interface
- `BUFID_WIDTH`, 9, width of a buffer ID.
- `BUFID_NUM`, 512, number of buffer IDs managed; 2 ≤ BUFID_NUM ≤ 2^BUFID_WIDTH.
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. One clock domain; reset polarity and synchronicity are fixed.
- `o_pkt_bufid_wr`  out  1  level valid: the presented ID is available.
- `ov_pkt_bufid`  out  BUFID_WIDTH  presented free ID.
- `i_pkt_bufid_ack`  in  1  one-cycle pulse: the presented ID is consumed.
- `i_pkt_bufid_free`  in  1  one-cycle pulse: return an ID to the pool.
- `iv_pkt_bufid_free`  in  BUFID_WIDTH  ID being returned.
- `ov_free_bufid_num`  out  BUFID_WIDTH+1  IDs held in the pool RAM. Excludes the presented slot.
- `o_init_done`  out  1  high once pool initialisation is complete.
- `o_free_err`  out  1  one-cycle pulse when a release is dropped.
- `ov_bufid_manage_state`  out  2  current FSM state, exported for debug.

## Operation
- **Pool storage**
  - Circular FIFO in RAM: BUFID_NUM × BUFID_WIDTH, synchronous read with 1-cycle latency.
  - `rd_ptr` and `wr_ptr` wrap from BUFID_NUM-1 to 0.
  - `count` is BUFID_WIDTH+1 bits wide and drives `ov_free_bufid_num`.
- **FSM states**
  - `INIT_S` (00): writes `ram[init_cnt] = init_cnt`, one entry per cycle.
    - After the entry at BUFID_NUM-1: `count` = BUFID_NUM, `wr_ptr` = 0, `o_init_done` <= 1, next state `FETCH_S`.
  - `FETCH_S` (01): if `count` > 0, read at `rd_ptr`, increment `rd_ptr`, decrement `count`, go to `WAIT_S`. Otherwise stay in `FETCH_S`.
  - `WAIT_S` (11): `ov_pkt_bufid` <= RAM data, `o_pkt_bufid_wr` <= 1, go to `PRESENT_S`.
  - `PRESENT_S` (10): hold `o_pkt_bufid_wr` and `ov_pkt_bufid` stable.
    - On `i_pkt_bufid_ack`: `o_pkt_bufid_wr` <= 0, `ov_pkt_bufid` <= 0, go to `FETCH_S`.
- **Ack handling:** `i_pkt_bufid_ack` outside `PRESENT_S` is ignored.
- **Release**
  - Outside `INIT_S`, with ID < BUFID_NUM and `count` < BUFID_NUM: write `ram[wr_ptr]`, increment `wr_ptr` and `count`.
  - A release is dropped, and `o_free_err` pulses for 1 cycle, in any of these cases:
    - it arrives during `INIT_S`;
    - the ID is ≥ BUFID_NUM;
    - `count` == BUFID_NUM (pool full, i.e. a double free).
- **Release and pop in the same cycle:** net `count` change is 0.
- **Pop gating:** the pop decision uses the pre-update `count`. A release into an empty pool can only be popped on the following cycle, so a read never collides with the same-cycle write.
- **ID order:** strictly FIFO. Released IDs are re-issued after all IDs already in the pool.
- **Reset**
  - All outputs go to 0 and the state goes to `INIT_S`.
  - Pointers, `count` and `init_cnt` are cleared.
  - Reset mid-operation discards all outstanding IDs and re-initialises the pool.

## Timing
- All outputs are registered. Reset values are all 0: `o_pkt_bufid_wr`, `ov_pkt_bufid`, `ov_free_bufid_num`, `o_init_done`, `o_free_err`, `ov_bufid_manage_state`.
- Cycle 0 is the first cycle with `reset` low.
  - Cycles 0..BUFID_NUM-1: `INIT_S`.
  - `o_init_done` = 1 from cycle BUFID_NUM.
  - `o_pkt_bufid_wr` = 1 with ID 0 from cycle BUFID_NUM+2.
- Ack sampled in cycle t:
  - `o_pkt_bufid_wr` = 0 in cycles t+1 and t+2.
  - Next ID is valid from t+3, provided `count` > 0 at t+1.
- Release sampled in cycle t: `ov_free_bufid_num` reflects it in cycle t+1.
- Empty pool with FSM waiting in `FETCH_S`, release sampled in cycle t: that ID is presented from t+3.

## Test plan
1. **Init:** BUFID_NUM=512, deassert reset.
   - Required: `o_pkt_bufid_wr` = 0 in cycles 0..513; `o_init_done` rises at cycle 512.
   - Required: `o_pkt_bufid_wr` = 1 with `ov_pkt_bufid` = 0 from cycle 514; `ov_free_bufid_num` = 511.
2. **Consume:** three acks, each sent when `o_pkt_bufid_wr` is high.
   - Required: IDs presented are 0, then 1, then 2; each new valid appears 3 cycles after its ack.
   - Required: `ov_free_bufid_num` ends at 508.
3. **Exhaust and refill:** BUFID_NUM=4; ack IDs 0..3.
   - Required: after the 4th ack, `o_pkt_bufid_wr` stays 0, `ov_free_bufid_num` = 0, FSM in `FETCH_S`.
   - Then release ID 2 at cycle t. Required: `o_pkt_bufid_wr` = 1 with `ov_pkt_bufid` = 2 at t+3.
4. **Simultaneous release and pop:** release ID 0 in the same cycle `FETCH_S` pops (BUFID_NUM=512).
   - Required: `ov_free_bufid_num` unchanged.
   - Required: ID 0 is re-issued only after ID 511.
5. **Errors:** BUFID_NUM=4, after init.
   - Release ID 0 twice: first accepted (`count` 3→4); second dropped with one `o_free_err` pulse, `count` stays 4.
   - Release ID 5: `o_free_err` pulse.
   - Release during `INIT_S`: `o_free_err` pulse.
6. **Reset mid-operation:** assert `reset` for 1 cycle while in `PRESENT_S` holding ID 7.
   - Required: all outputs 0 the next cycle.
   - Required: the init sequence repeats and the first ID presented is 0 again.
